// File: rtl/pipe_ctrl_seq.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_seq
//
// Pipeline sequencing controller. Merges the per-cycle hazard requests
// (load-use stall, control-flow flush) with a multi-cycle multiply/divide
// occupancy FSM and drives the per-stage pipeline-register enables and flush
// strobes. Also keeps stall-cycle and flush-event performance counters.
//
// Parameters:
//   MUL_LAT  total EX-occupancy cycles of a multiply (2..255)
//   DIV_LAT  total EX-occupancy cycles of a divide   (2..255)
//   PERF_W   width of each performance counter
//
// Ports:
//   i_CLK           pipeline clock, rising edge
//   i_RST_N         asynchronous active-low reset
//   i_stall         load-use stall request
//   i_flush         control-flow flush request resolved in ID
//   i_mdu_start     instruction in EX is a multi-cycle MDU op
//   i_mdu_div       qualifies i_mdu_start: 1 = divide, 0 = multiply
//   i_clr_perf      synchronous clear of both performance counters
//   o_pc_en         PC write enable
//   o_if_id_en      IF/ID register enable
//   o_if_id_flush   IF/ID register clear (NOP)
//   o_id_ex_en      ID/EX register enable
//   o_id_ex_flush   ID/EX register clear (bubble)
//   o_ex_mem_flush  EX/MEM register clear (bubble)
//   o_mdu_busy      high while in MDU state
//   o_mdu_done      one-cycle pulse on the MDU release cycle
//   o_stall_cnt     cycles with o_pc_en = 0
//   o_flush_cnt     cycles with o_if_id_flush = 1
// ---------------------------------------------------------------------------
module pipe_ctrl_seq #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_mdu_start,
    input  logic              i_mdu_div,
    input  logic              i_clr_perf,
    output logic              o_pc_en,
    output logic              o_if_id_en,
    output logic              o_if_id_flush,
    output logic              o_id_ex_en,
    output logic              o_id_ex_flush,
    output logic              o_ex_mem_flush,
    output logic              o_mdu_busy,
    output logic              o_mdu_done,
    output logic [PERF_W-1:0] o_stall_cnt,
    output logic [PERF_W-1:0] o_flush_cnt
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MDU = 1'b1
    } state_t;

    // The start cycle itself is one occupancy cycle and the release cycle is
    // another, so the counter covers only the cycles in between.
    localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 2);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 2);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PERF_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic freeze;      // hold PC, IF/ID, ID/EX and bubble EX/MEM
    logic hazard_ok;   // stall/flush requests are honoured this cycle
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush;
    logic mdu_done;

    // -----------------------------------------------------------------------
    // Next-state and strobe logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        freeze       = 1'b0;
        hazard_ok    = 1'b0;
        mdu_done     = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (i_mdu_start) begin
                    freeze  = 1'b1;
                    cnt_d   = i_mdu_div ? DIV_LOAD : MUL_LOAD;
                    state_d = ST_MDU;
                end else begin
                    hazard_ok = 1'b1;
                end
            end
            ST_MDU: begin
                if (cnt_q != 8'd0) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q - 8'd1;
                end else begin
                    // Release cycle: the MDU op leaves EX at the end of this
                    // cycle, so ordinary hazards apply again; a new start is
                    // only honoured once back in RUN.
                    mdu_done  = 1'b1;
                    hazard_ok = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end

        if (hazard_ok) begin
            if (i_stall) begin
                // Branch operands are not valid yet, so a concurrent flush
                // request is dropped; it will be re-raised next cycle.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (i_flush) begin
                if_id_flush = 1'b1;
            end
        end

        // While reset is held the pipeline is fully frozen and quiet.
        if (!i_RST_N) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            mdu_done     = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State register and performance counters
    // -----------------------------------------------------------------------
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q     <= ST_RUN;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value, independent of order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (i_clr_perf) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (!pc_en)      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
                if (if_id_flush) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign o_pc_en        = pc_en;
    assign o_if_id_en     = if_id_en;
    assign o_if_id_flush  = if_id_flush;
    assign o_id_ex_en     = id_ex_en;
    assign o_id_ex_flush  = id_ex_flush;
    assign o_ex_mem_flush = ex_mem_flush;
    assign o_mdu_busy     = (state_q == ST_MDU);
    assign o_mdu_done     = mdu_done;
    assign o_stall_cnt    = stall_cnt_q;
    assign o_flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_seq
//
// Scoreboard bench for pipe_ctrl_seq. Each driven cycle pushes the expected
// strobe vector and counter values; a negedge monitor pops and compares.
// A second, narrow instance (PERF_W = 3, MUL_LAT = 2) exercises counter
// wrap and the shortest MDU latency.
//
// Strobe vector bit order:
//   [7] pc_en [6] if_id_en [5] if_id_flush [4] id_ex_en
//   [3] id_ex_flush [2] ex_mem_flush [1] mdu_busy [0] mdu_done
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_seq;

    localparam logic [7:0] S_RST   = 8'h00;
    localparam logic [7:0] S_IDLE  = 8'hD0;
    localparam logic [7:0] S_STALL = 8'h18;
    localparam logic [7:0] S_FLUSH = 8'hF0;
    localparam logic [7:0] S_FRZ   = 8'h04;  // mdu_start cycle, still RUN
    localparam logic [7:0] S_BUSY  = 8'h06;  // freeze while in MDU
    localparam logic [7:0] S_DONE  = 8'h03;  // busy + done, OR-ed on release

    typedef struct {
        string       tag;
        logic [7:0]  strb;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, stall, flush, mdu_start, mdu_div, clr_perf;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush;
    logic mdu_busy, mdu_done;
    logic [31:0] stall_cnt, flush_cnt;
    logic [7:0]  strb;

    logic w_stall, w_start;
    logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_flush;
    logic w_ex_mem_flush, w_busy, w_done;
    logic [2:0] w_stall_cnt, w_flush_cnt;
    logic [7:0] w_strb;

    exp_t        sb[$];
    logic [31:0] exp_stall, exp_flush;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_seq #(.MUL_LAT(4), .DIV_LAT(32), .PERF_W(32)) u_dut (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_stall        (stall),
        .i_flush        (flush),
        .i_mdu_start    (mdu_start),
        .i_mdu_div      (mdu_div),
        .i_clr_perf     (clr_perf),
        .o_pc_en        (pc_en),
        .o_if_id_en     (if_id_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_en     (id_ex_en),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_flush (ex_mem_flush),
        .o_mdu_busy     (mdu_busy),
        .o_mdu_done     (mdu_done),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    pipe_ctrl_seq #(.MUL_LAT(2), .DIV_LAT(3), .PERF_W(3)) u_dut_w (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_stall        (w_stall),
        .i_flush        (1'b0),
        .i_mdu_start    (w_start),
        .i_mdu_div      (1'b0),
        .i_clr_perf     (1'b0),
        .o_pc_en        (w_pc_en),
        .o_if_id_en     (w_if_id_en),
        .o_if_id_flush  (w_if_id_flush),
        .o_id_ex_en     (w_id_ex_en),
        .o_id_ex_flush  (w_id_ex_flush),
        .o_ex_mem_flush (w_ex_mem_flush),
        .o_mdu_busy     (w_busy),
        .o_mdu_done     (w_done),
        .o_stall_cnt    (w_stall_cnt),
        .o_flush_cnt    (w_flush_cnt)
    );

    assign strb   = {pc_en, if_id_en, if_id_flush, id_ex_en,
                     id_ex_flush, ex_mem_flush, mdu_busy, mdu_done};
    assign w_strb = {w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en,
                     w_id_ex_flush, w_ex_mem_flush, w_busy, w_done};

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_strb"}, 64'(strb), 64'(e.strb));
            check({e.tag, "_scnt"}, 64'(stall_cnt), 64'(e.sc));
            check({e.tag, "_fcnt"}, 64'(flush_cnt), 64'(e.fc));
        end
    end

    // Drive one cycle (entered just after a rising edge), push expectations,
    // then advance the counter model using the expected strobes.
    task automatic cycle(input string tag, input logic rn, input logic st,
                         input logic fl, input logic ms, input logic md,
                         input logic cl, input logic [7:0] es);
        exp_t e;
        rst_n     = rn;
        stall     = st;
        flush     = fl;
        mdu_start = ms;
        mdu_div   = md;
        clr_perf  = cl;
        if (!rn) begin
            exp_stall = '0;
            exp_flush = '0;
        end
        e.tag  = tag;
        e.strb = es;
        e.sc   = exp_stall;
        e.fc   = exp_flush;
        sb.push_back(e);
        @(negedge clk);
        if (!rn || cl) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (!es[7]) exp_stall = exp_stall + 32'd1;
            if (es[5])  exp_flush = exp_flush + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mdu_start = 1'b0;
        mdu_div = 1'b0; clr_perf = 1'b0; w_stall = 1'b0; w_start = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        @(posedge clk);
        #1;

        // Reset held across three edges, then released with inputs idle.
        for (int i = 0; i < 3; i++) cycle("rst", 0, 0, 0, 0, 0, 0, S_RST);
        cycle("idle", 1, 0, 0, 0, 0, 0, S_IDLE);
        cycle("idle", 1, 0, 0, 0, 0, 0, S_IDLE);

        // Single load-use stall.
        cycle("stall", 1, 1, 0, 0, 0, 0, S_STALL);
        cycle("post_stall", 1, 0, 0, 0, 0, 0, S_IDLE);

        // Stall and flush together: stall wins; then flush alone.
        cycle("stall_flush", 1, 1, 1, 0, 0, 0, S_STALL);
        cycle("flush", 1, 0, 1, 0, 0, 0, S_FLUSH);
        cycle("post_flush", 1, 0, 0, 0, 0, 0, S_IDLE);

        // Multiply, MUL_LAT = 4; hazard inputs ignored while busy.
        cycle("clr", 1, 0, 0, 0, 0, 1, S_IDLE);
        cycle("mul_start", 1, 1, 1, 1, 0, 0, S_FRZ);
        cycle("mul_busy", 1, 0, 1, 0, 0, 0, S_BUSY);
        cycle("mul_busy", 1, 1, 0, 1, 0, 0, S_BUSY);
        cycle("mul_rel", 1, 0, 0, 0, 0, 0, S_IDLE | S_DONE);
        cycle("mul_after", 1, 0, 0, 0, 0, 0, S_IDLE);
        check("mul_stall_cnt", 64'(stall_cnt), 64'd3);

        // Divide, DIV_LAT = 32, with flush held throughout.
        cycle("clr", 1, 0, 0, 0, 0, 1, S_IDLE);
        cycle("div_start", 1, 0, 1, 1, 1, 0, S_FRZ);
        for (int i = 0; i < 30; i++) cycle("div_busy", 1, 0, 1, 0, 0, 0, S_BUSY);
        cycle("div_rel", 1, 0, 1, 0, 0, 0, S_FLUSH | S_DONE);
        cycle("div_after", 1, 0, 0, 0, 0, 0, S_IDLE);
        check("div_stall_cnt", 64'(stall_cnt), 64'd31);
        check("div_flush_cnt", 64'(flush_cnt), 64'd1);

        // Multiply whose release cycle sees a stall and a (ignored) start,
        // followed by a back-to-back start that must be honoured in RUN.
        cycle("mul2_start", 1, 0, 0, 1, 0, 0, S_FRZ);
        cycle("mul2_busy", 1, 0, 0, 0, 0, 0, S_BUSY);
        cycle("mul2_busy", 1, 0, 0, 0, 0, 0, S_BUSY);
        cycle("mul2_rel", 1, 1, 0, 1, 0, 0, S_STALL | S_DONE);
        cycle("mul3_start", 1, 0, 0, 1, 0, 0, S_FRZ);
        cycle("mul3_busy", 1, 0, 0, 0, 0, 0, S_BUSY);
        cycle("mul3_busy", 1, 0, 0, 0, 0, 0, S_BUSY);
        cycle("mul3_rel", 1, 0, 0, 0, 0, 0, S_IDLE | S_DONE);
        cycle("mul3_after", 1, 0, 0, 0, 0, 0, S_IDLE);

        // Reset asserted mid-divide, at T+10.
        cycle("div2_start", 1, 0, 0, 1, 1, 0, S_FRZ);
        for (int i = 0; i < 9; i++) cycle("div2_busy", 1, 0, 0, 0, 0, 0, S_BUSY);
        cycle("mid_rst", 0, 0, 0, 0, 0, 0, S_RST);
        cycle("mid_rst", 0, 0, 0, 0, 0, 0, S_RST);
        cycle("rel_idle", 1, 0, 0, 0, 0, 0, S_IDLE);
        cycle("mul4_start", 1, 0, 0, 1, 0, 0, S_FRZ);
        cycle("mul4_busy", 1, 0, 0, 0, 0, 0, S_BUSY);
        cycle("mul4_busy", 1, 0, 0, 0, 0, 0, S_BUSY);
        cycle("mul4_rel", 1, 0, 0, 0, 0, 0, S_IDLE | S_DONE);
        cycle("mul4_after", 1, 0, 0, 0, 0, 0, S_IDLE);
        check("rst_mul_stall_cnt", 64'(stall_cnt), 64'd3);

        // Clear takes priority over an increment in the same cycle.
        cycle("clr_stall", 1, 1, 0, 0, 0, 1, S_STALL);
        cycle("post_clr", 1, 0, 0, 0, 0, 0, S_IDLE);
        check("clr_stall_cnt", 64'(stall_cnt), 64'd0);

        // Narrow instance: 3-bit stall counter wraps after 8 stalls.
        for (int i = 0; i < 8; i++) begin
            w_stall = 1'b1;
            @(negedge clk);
            check("w_stall_strb", 64'(w_strb), 64'(S_STALL));
            check("w_stall_cnt", 64'(w_stall_cnt), 64'(i));
            @(posedge clk);
            #1;
        end
        w_stall = 1'b0;
        @(negedge clk);
        check("w_wrap_cnt", 64'(w_stall_cnt), 64'd0);
        @(posedge clk);
        #1;

        // Narrow instance: MUL_LAT = 2 enters MDU with cnt = 0.
        w_start = 1'b1;
        @(negedge clk);
        check("w_lat2_start", 64'(w_strb), 64'(S_FRZ));
        @(posedge clk);
        #1;
        w_start = 1'b0;
        @(negedge clk);
        check("w_lat2_rel", 64'(w_strb), 64'(S_IDLE | S_DONE));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("w_lat2_after", 64'(w_strb), 64'(S_IDLE));
        check("w_lat2_cnt", 64'(w_stall_cnt), 64'd1);

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_seq.md
# pipe_ctrl_seq

Pipeline sequencing controller for the hardware-scheduled MIPS pipeline. It merges the per-cycle hazard requests (load-use stall, control-flow flush) with a multi-cycle multiply/divide occupancy state machine and drives the per-stage pipeline-register enable and flush strobes. It also keeps stall-cycle and flush-event performance counters. It sits between the hazard detection logic and the PC, IF/ID, ID/EX and EX/MEM registers.

## Interface
Parameters:
- MUL_LAT, 4: total EX-occupancy cycles of a multiply; legal range 2..255.
- DIV_LAT, 32: total EX-occupancy cycles of a divide; legal range 2..255.
- PERF_W, 32: width of each performance counter.

Ports:
- i_CLK  in  1  pipeline clock; all state updates on the rising edge.
- i_RST_N  in  1  asynchronous, active-low reset.
- i_stall  in  1  load-use stall request from hazard detection.
- i_flush  in  1  control-flow flush request (branch taken, jump, jump-register) resolved in ID.
- i_mdu_start  in  1  instruction currently in EX is a multi-cycle MDU op.
- i_mdu_div  in  1  qualifies i_mdu_start: 1 = divide, 0 = multiply.
- i_clr_perf  in  1  synchronous clear of both performance counters.
- o_pc_en  out  1  PC write enable.
- o_if_id_en  out  1  IF/ID register enable.
- o_if_id_flush  out  1  IF/ID register clear (insert NOP).
- o_id_ex_en  out  1  ID/EX register enable.
- o_id_ex_flush  out  1  ID/EX register clear (bubble).
- o_ex_mem_flush  out  1  EX/MEM register clear (bubble).
- o_mdu_busy  out  1  high while in MDU state.
- o_mdu_done  out  1  one-cycle pulse on the MDU release cycle.
- o_stall_cnt  out  PERF_W  count of cycles with o_pc_en = 0.
- o_flush_cnt  out  PERF_W  count of cycles with o_if_id_flush = 1.

## Operation
- State register: RUN or MDU, plus an 8-bit down-counter cnt.
- All strobe outputs are combinational from state, cnt and the inputs. Defaults: all enables = 1 and all flushes = 0.
- RUN state, priority mdu_start > stall > flush:
  - i_mdu_start: o_pc_en, o_if_id_en and o_id_ex_en = 0; o_ex_mem_flush = 1. Load cnt with (i_mdu_div ? DIV_LAT : MUL_LAT) - 2 and go to MDU. i_stall and i_flush are ignored that cycle.
  - i_stall, without mdu_start: o_pc_en = 0, o_if_id_en = 0, o_id_ex_flush = 1. i_flush is suppressed, because the branch operands are not yet valid.
  - i_flush alone: o_if_id_flush = 1.
- MDU state, cnt != 0: same freeze pattern as the mdu_start cycle. cnt decrements. i_stall, i_flush and i_mdu_start are ignored.
- MDU state, cnt == 0 (release cycle):
  - o_mdu_done = 1.
  - Strobes follow the RUN rules for i_stall and i_flush; i_mdu_start is ignored.
  - Next state is RUN.
- o_mdu_busy = 1 exactly when the state is MDU.
- Performance counters:
  - o_stall_cnt increments on every cycle with o_pc_en = 0.
  - o_flush_cnt increments on every cycle with o_if_id_flush = 1.
  - Both wrap modulo 2^PERF_W.
  - i_clr_perf has priority over increment; the counters read 0 the next cycle.

## Timing
- Reset (i_RST_N low), asynchronous:
  - State = RUN, cnt = 0, both counters = 0.
  - While reset is held: all enables = 0, all flushes = 0, o_mdu_busy = 0, o_mdu_done = 0.
  - Reset asserted mid-MDU abandons the operation; the first cycle after release is RUN.
- MDU op with i_mdu_start high at cycle T:
  - The instruction occupies EX for cycles T..T+LAT-1 and advances at the end of T+LAT-1.
  - o_pc_en is low for LAT-1 cycles (T..T+LAT-2), then high at T+LAT-1 unless i_stall is asserted.
  - With LAT = 2, MDU is entered with cnt = 0, so the release cycle is T+1.
- Back-to-back MDU ops: i_mdu_start for the next instruction is honoured at the earliest at T+LAT, which is in RUN state.
- No latency on stall or flush: strobes respond in the same cycle as the request.

## Test plan
- Reset sequence: hold i_RST_N low across 3 edges, then release with all inputs 0.
  - During reset: all enables 0, all flushes 0, both counters 0.
  - After release: all enables 1, no flushes.
- Load-use stall: i_stall for 1 cycle.
  - That cycle: o_pc_en = 0, o_if_id_en = 0, o_id_ex_flush = 1.
  - Next cycle: all enables 1. o_stall_cnt = 1.
- Stall and flush in the same cycle: stall pattern only, o_if_id_flush = 0. Next cycle i_flush alone gives o_if_id_flush = 1 and o_flush_cnt = 1.
- Multiply with MUL_LAT = 4: i_mdu_start at T.
  - o_pc_en low for T..T+2; o_mdu_busy high for T+1..T+3.
  - o_mdu_done pulses at T+3; o_stall_cnt = 3.
- Divide with DIV_LAT = 32 and i_flush held throughout:
  - o_if_id_flush = 0 until the release cycle T+31, where it is 1.
  - o_stall_cnt = 31, o_flush_cnt = 1.
- Mid-divide reset: assert i_RST_N low at T+10.
  - State = RUN and o_mdu_busy = 0 immediately.
  - After release, i_mdu_start (MUL_LAT = 4) completes normally in 4 cycles.
- Counter behaviour:
  - Preload o_stall_cnt by forcing it to 2^32-1, then stall 1 cycle: reads 0.
  - i_clr_perf together with an active stall: reads 0 next cycle.
